// File: rtl/ctrl_pkg.sv
// Shared encodings for the run/result controller: FSM states and display page codes.
// Pure declarations; no logic, no latency.
package ctrl_pkg;
   typedef enum logic [1:0] {
      HOLD = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] PG_XY   = 2'd0;
   localparam logic [1:0] PG_SAD  = 2'd1;
   localparam logic [1:0] PG_CYC  = 2'd2;
   localparam logic [1:0] PG_LAST = 2'd2;
endpackage

// File: rtl/run_result_ctrl_if.sv
// Datapath observation inputs and run/result/display outputs of the run controller.
// master = controller side, slave = datapath/display side; no flow control, all signals sampled every cycle.
interface run_result_ctrl_if;
   logic [31:0] PC;
   logic [31:0] v0_in;
   logic [31:0] v1_in;
   logic [31:0] sad_in;
   logic        core_rst;
   logic        done;
   logic        timeout;
   logic [1:0]  page;
   logic [15:0] NumberA;
   logic [15:0] NumberB;
   logic [31:0] run_cycles;

   modport master (
      input  PC, v0_in, v1_in, sad_in,
      output core_rst, done, timeout, page, NumberA, NumberB, run_cycles
   );

   modport slave (
      output PC, v0_in, v1_in, sad_in,
      input  core_rst, done, timeout, page, NumberA, NumberB, run_cycles
   );
endinterface

// File: rtl/page_rotator.sv
// Cycles the display page 0->1->2->0, holding each for DWELL cycles while enabled.
// Page and tick are registered (tick pulses on the edge the page changes); disabled = counter and page held at 0.
module page_rotator
   import ctrl_pkg::*;
#(
   parameter logic [31:0] DWELL = 32'd100_000_000
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       enable,
   output logic [1:0] page,
   output logic       tick
);
   logic [31:0] dwell_cnt;

   always_ff @(posedge Clk) begin
      if (Reset || !enable) begin
         dwell_cnt <= '0;
         page      <= PG_XY;
         tick      <= 1'b0;
      end else if (dwell_cnt == DWELL - 32'd1) begin
         dwell_cnt <= '0;
         tick      <= 1'b1;
         page      <= (page == PG_LAST) ? PG_XY : page + 2'd1;
      end else begin
         dwell_cnt <= dwell_cnt + 32'd1;
         tick      <= 1'b0;
      end
   end
endmodule

// File: rtl/run_result_ctrl.sv
// Holds the core in reset, runs it until PC stalls or a timeout, then freezes and pages the results.
// All outputs registered; display follows a page change by one cycle; no backpressure.
module run_result_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned RST_CYCLES  = 4,
   parameter int unsigned STALL_LIMIT = 8,
   parameter logic [31:0] TIMEOUT     = 32'd1_000_000,
   parameter logic [31:0] DWELL       = 32'd100_000_000
) (
   input logic               Clk,
   input logic               Reset,
   run_result_ctrl_if.master bus
);
   state_t      state;
   logic [31:0] hold_cnt, stall_cnt, prev_pc, run_cnt, run_next;
   logic [15:0] cap_x, cap_y, num_a, num_b;
   logic [31:0] cap_sad;
   logic        first_run, core_rst_q, done_q, timeout_q, shown;
   logic        pc_match, halt, tmo, tick;
   logic [1:0]  page;
   logic        unused_hi;

   assign unused_hi = ^{bus.v0_in[31:16], bus.v1_in[31:16]};

   always_comb begin
      pc_match = !first_run && (bus.PC == prev_pc);
      halt     = pc_match && (stall_cnt + 32'd1 == STALL_LIMIT - 1);
      tmo      = (run_cnt == TIMEOUT - 32'd1);
      run_next = (run_cnt == '1) ? run_cnt : run_cnt + 32'd1;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= HOLD;
         core_rst_q <= 1'b1;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
         hold_cnt   <= '0;
         stall_cnt  <= '0;
         prev_pc    <= '0;
         run_cnt    <= '0;
         first_run  <= 1'b0;
         cap_x      <= '0;
         cap_y      <= '0;
         cap_sad    <= '0;
      end else begin
         case (state)
            HOLD: begin
               core_rst_q <= 1'b1;
               if (hold_cnt == RST_CYCLES - 1) begin
                  state      <= RUN;
                  core_rst_q <= 1'b0;
                  prev_pc    <= '0;
                  stall_cnt  <= '0;
                  first_run  <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + 32'd1;
               end
            end
            RUN: begin
               run_cnt   <= run_next;
               prev_pc   <= bus.PC;
               first_run <= 1'b0;
               stall_cnt <= pc_match ? stall_cnt + 32'd1 : '0;
               // A genuine halt outranks a coincident timeout.
               if (halt || tmo) begin
                  state     <= DONE;
                  done_q    <= 1'b1;
                  timeout_q <= !halt;
                  cap_x     <= bus.v0_in[15:0];
                  cap_y     <= bus.v1_in[15:0];
                  cap_sad   <= bus.sad_in;
               end
            end
            DONE: begin
               done_q <= 1'b1;
            end
            default: state <= HOLD;
         endcase
      end
   end

   page_rotator #(.DWELL(DWELL)) u_rot (
      .Clk    (Clk),
      .Reset  (Reset),
      .enable (done_q),
      .page   (page),
      .tick   (tick)
   );

   // Display reloads on entry to DONE and on every page change.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         num_a <= '0;
         num_b <= '0;
         shown <= 1'b0;
      end else if (done_q && (!shown || tick)) begin
         shown <= 1'b1;
         case (page)
            PG_XY:   begin num_a <= cap_y;          num_b <= cap_x;          end
            PG_SAD:  begin num_a <= cap_sad[31:16]; num_b <= cap_sad[15:0];  end
            PG_CYC:  begin num_a <= run_cnt[31:16]; num_b <= run_cnt[15:0];  end
            default: begin num_a <= '0;             num_b <= '0;             end
         endcase
      end
   end

   assign bus.core_rst   = core_rst_q;
   assign bus.done       = done_q;
   assign bus.timeout    = timeout_q;
   assign bus.page       = page;
   assign bus.NumberA    = num_a;
   assign bus.NumberB    = num_b;
   assign bus.run_cycles = run_cnt;
endmodule

// File: tb/tb_run_result_ctrl.sv
// Self-checking bench for run_result_ctrl against a sequence-level model of halt/timeout and paging.
module tb_run_result_ctrl;
   import ctrl_pkg::*;

   localparam int unsigned RC = 4;
   localparam int unsigned SL = 3;
   localparam logic [31:0] TO = 32'd20;
   localparam logic [31:0] DW = 32'd5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] pc_a [64];
   logic [31:0] v0_a [64];
   logic [31:0] v1_a [64];
   logic [31:0] sad_a[64];
   int          exp_k;
   bit          exp_tmo;

   run_result_ctrl_if bus();

   run_result_ctrl #(.RST_CYCLES(RC), .STALL_LIMIT(SL), .TIMEOUT(TO), .DWELL(DW)) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_rand();
      bus.PC     = $urandom;
      bus.v0_in  = $urandom;
      bus.v1_in  = $urandom;
      bus.sad_in = $urandom;
   endtask

   // Run ends at the first cycle whose last SL PC samples are identical, else at cycle TO.
   task automatic model_end();
      bit same;
      exp_k   = 0;
      exp_tmo = 0;
      for (int k = 1; k <= int'(TO) && exp_k == 0; k++) begin
         same = (k >= int'(SL));
         for (int j = k - int'(SL); same && j < k - 1; j++)
            if (pc_a[j] != pc_a[j+1]) same = 0;
         if (same) begin
            exp_k = k; exp_tmo = 0;
         end else if (k == int'(TO)) begin
            exp_k = k; exp_tmo = 1;
         end
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) step();
      rst = 1'b0;
   endtask

   task automatic run_hold();
      for (int i = 1; i <= int'(RC); i++) begin
         drive_rand();
         step();
         checks++;
         if (bus.core_rst !== (i < int'(RC))) begin
            errors++;
            $display("FAIL hold_core_rst cyc %0d got %b exp %b", i, bus.core_rst, (i < int'(RC)));
         end
         checks++;
         if (bus.done !== 1'b0 || bus.NumberA !== 16'h0 || bus.NumberB !== 16'h0) begin
            errors++;
            $display("FAIL hold_outputs cyc %0d got done %b A %h B %h exp 0 0 0", i, bus.done, bus.NumberA, bus.NumberB);
         end
      end
   endtask

   task automatic run_to_done();
      model_end();
      for (int k = 1; k <= exp_k; k++) begin
         bus.PC     = pc_a[k-1];
         bus.v0_in  = v0_a[k-1];
         bus.v1_in  = v1_a[k-1];
         bus.sad_in = sad_a[k-1];
         step();
         checks++;
         if (bus.done !== (k == exp_k) || bus.core_rst !== 1'b0) begin
            errors++;
            $display("FAIL run_done cyc %0d got done %b core_rst %b exp done %b core_rst 0",
                     k, bus.done, bus.core_rst, (k == exp_k));
         end
      end
      checks++;
      if (bus.timeout !== exp_tmo || bus.run_cycles !== 32'(exp_k)) begin
         errors++;
         $display("FAIL run_result got timeout %b cycles %0d exp timeout %b cycles %0d",
                  bus.timeout, bus.run_cycles, exp_tmo, exp_k);
      end
   endtask

   task automatic check_display(input int n);
      logic [1:0]  pg, dp;
      logic [31:0] v0, v1, sd;
      logic [15:0] ea, eb;
      v0 = v0_a[exp_k-1];
      v1 = v1_a[exp_k-1];
      sd = sad_a[exp_k-1];
      for (int t = 1; t <= n; t++) begin
         drive_rand();
         step();
         pg = 2'((t / int'(DW)) % 3);
         dp = 2'(((t - 1) / int'(DW)) % 3);
         case (dp)
            2'd0:    begin ea = v1[15:0];           eb = v0[15:0];           end
            2'd1:    begin ea = sd[31:16];          eb = sd[15:0];           end
            default: begin ea = 16'(exp_k >> 16);   eb = 16'(exp_k);         end
         endcase
         checks++;
         if (bus.page !== pg || bus.NumberA !== ea || bus.NumberB !== eb) begin
            errors++;
            $display("FAIL display t %0d got page %0d A %h B %h exp page %0d A %h B %h",
                     t, bus.page, bus.NumberA, bus.NumberB, pg, ea, eb);
         end
         checks++;
         if (bus.done !== 1'b1 || bus.run_cycles !== 32'(exp_k) || bus.core_rst !== 1'b0) begin
            errors++;
            $display("FAIL frozen t %0d got done %b cycles %0d core_rst %b exp 1 %0d 0",
                     t, bus.done, bus.run_cycles, bus.core_rst, exp_k);
         end
      end
   endtask

   task automatic check_reset_vals(input string tag);
      checks++;
      if (bus.core_rst !== 1'b1 || bus.done !== 1'b0 || bus.timeout !== 1'b0 || bus.page !== 2'd0 ||
          bus.NumberA !== 16'h0 || bus.NumberB !== 16'h0 || bus.run_cycles !== 32'h0) begin
         errors++;
         $display("FAIL %s got core_rst %b done %b tmo %b page %0d A %h B %h cyc %0d exp 1 0 0 0 0 0 0",
                  tag, bus.core_rst, bus.done, bus.timeout, bus.page, bus.NumberA, bus.NumberB, bus.run_cycles);
      end
   endtask

   task automatic test_reset();
      drive_rand();
      do_reset(2);
      check_reset_vals("reset_state");
      run_hold();
   endtask

   task automatic test_halt();
      logic [31:0] seq [6];
      seq = '{32'h0, 32'h4, 32'h8, 32'h20, 32'h20, 32'h20};
      for (int i = 0; i < 64; i++) begin
         pc_a[i] = (i < 6) ? seq[i] : 32'h20;
         v0_a[i] = 32'h0005; v1_a[i] = 32'h0003; sad_a[i] = 32'h0001_0002;
      end
      do_reset(2);
      run_hold();
      run_to_done();
      checks++;
      if (exp_k != 6 || exp_tmo) begin
         errors++;
         $display("FAIL halt_model got k %0d tmo %b exp k 6 tmo 0", exp_k, exp_tmo);
      end
      check_display(16);
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 64; i++) begin
         pc_a[i] = 32'(4 * ((i / 2) % 3 + 1));
         v0_a[i] = $urandom; v1_a[i] = $urandom; sad_a[i] = $urandom;
      end
      do_reset(1);
      run_hold();
      run_to_done();
      checks++;
      if (bus.timeout !== 1'b1 || bus.run_cycles !== 32'd20) begin
         errors++;
         $display("FAIL timeout_case got tmo %b cycles %0d exp 1 20", bus.timeout, bus.run_cycles);
      end
      check_display(12);
   endtask

   task automatic test_boundary();
      for (int i = 0; i < 64; i++) begin
         pc_a[i] = (i < 17) ? 32'(32'h100 + 4 * i) : 32'h500;
         v0_a[i] = $urandom; v1_a[i] = $urandom; sad_a[i] = $urandom;
      end
      do_reset(1);
      run_hold();
      run_to_done();
      checks++;
      if (bus.timeout !== 1'b0 || bus.run_cycles !== 32'd20) begin
         errors++;
         $display("FAIL halt_wins got tmo %b cycles %0d exp 0 20", bus.timeout, bus.run_cycles);
      end
      check_display(6);
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 64; i++) begin
            pc_a[i] = 32'($urandom_range(0, 2) * 4);
            v0_a[i] = $urandom; v1_a[i] = $urandom; sad_a[i] = $urandom;
         end
         do_reset(1);
         run_hold();
         run_to_done();
         check_display(11);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 64; i++) begin
         pc_a[i] = 32'(4 * ((i / 2) % 3 + 1));
         v0_a[i] = $urandom; v1_a[i] = $urandom; sad_a[i] = $urandom;
      end
      do_reset(1);
      run_hold();
      for (int k = 0; k < 7; k++) begin
         bus.PC = pc_a[k];
         step();
      end
      do_reset(1);
      check_reset_vals("reset_mid_run");
      run_hold();
      run_to_done();
      check_display(7);
      do_reset(1);
      check_reset_vals("reset_mid_done");
      run_hold();
      checks++;
      if (bus.run_cycles !== 32'h0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL restart got cycles %0d done %b exp 0 0", bus.run_cycles, bus.done);
      end
   endtask

   initial begin
      test_reset();
      test_halt();
      test_timeout();
      test_boundary();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/run_result_ctrl.md
Name: run_result_ctrl

Overview:
- Sequences one run of the pipelined datapath executing the SAD motion-search program.
- Holds the core in reset for a fixed time after system reset, then releases it and watches PC to detect program completion (PC stalled) or a runaway program (timeout).
- On completion, freezes the v0/v1/min-SAD results and the run cycle count.
- Rotates the frozen results through pages on the two 16-bit number inputs of the 8-digit seven-segment display driver.

Parameters:
- RST_CYCLES, 4, cycles core reset stays asserted after Reset deasserts (min 1).
- STALL_LIMIT, 8, consecutive cycles of unchanged PC that mean the program has halted (min 2).
- TIMEOUT, 32'd1_000_000, RUN cycles after which completion is forced.
- DWELL, 32'd100_000_000, cycles each display page is held (min 1).

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- PC  in  32  datapath program counter
- v0_in  in  32  datapath $v0 (x coordinate)
- v1_in  in  32  datapath $v1 (y coordinate)
- sad_in  in  32  datapath current minimum SAD
- core_rst  out  1  reset to datapath Rst
- done  out  1  run finished, results frozen
- timeout  out  1  run ended by TIMEOUT, not by stall
- page  out  2  displayed page index
- NumberA  out  16  left display value
- NumberB  out  16  right display value
- run_cycles  out  32  RUN cycles counted, saturating

Behaviour:
- One clock domain. Reset is synchronous and active-high, and has priority over everything in any state.
- Reset values:
  - state=HOLD, core_rst=1, done=0, timeout=0, page=0.
  - NumberA=0, NumberB=0, run_cycles=0.
  - hold counter=0, stall counter=0, prev_pc=0, dwell counter=0, captured registers=0.
- HOLD state:
  - core_rst=1; hold counter increments each cycle.
  - When the counter reaches RST_CYCLES-1: go to RUN and clear prev_pc and the stall counter.
  - core_rst is therefore high exactly RST_CYCLES cycles after Reset falls.
- RUN state:
  - core_rst=0; run_cycles increments each cycle and saturates at 32'hFFFF_FFFF.
  - Each cycle prev_pc<=PC. If PC==prev_pc the stall counter increments; otherwise it clears to 0. The first RUN cycle never counts as a match.
  - Halt: the stall counter reaching STALL_LIMIT-1 while PC==prev_pc. Next state is DONE with timeout=0.
  - Timeout: run_cycles reaching TIMEOUT-1. Next state is DONE with timeout=1.
  - If both occur in the same cycle, halt wins (timeout=0).
  - On the transition cycle, capture v0_in, v1_in, sad_in and the final run_cycles (the value including this cycle).
- DONE state:
  - done=1; core_rst stays 0 (core keeps running, results are frozen); run_cycles holds.
  - Dwell counter counts 0..DWELL-1. On wrap, page advances 0→1→2→0. Page 3 is never produced.
  - Display pages, registered (outputs update 1 cycle after page changes):
    - page 0: NumberA=v1[15:0], NumberB=v0[15:0] (y, x).
    - page 1: NumberA=sad[31:16], NumberB=sad[15:0].
    - page 2: NumberA=run_cycles[31:16], NumberB=run_cycles[15:0].
  - DONE is left only by Reset.
- Before DONE: NumberA=0, NumberB=0, page=0.
- Reset asserted mid-RUN or mid-DONE: all state returns to reset values on the next edge; captured results are lost.
- Arithmetic is unsigned throughout; comparisons are equality only.

Decomposition:
- Shared package (ctrl_pkg):
  - state encoding HOLD=2'd0, RUN=2'd1, DONE=2'd2.
  - page codes PG_XY=2'd0, PG_SAD=2'd1, PG_CYC=2'd2.
  - PG_LAST=2'd2.
- One sub-module, page_rotator:
  - Ports: Clk, Reset, enable, out page, out tick.
  - Contains the dwell counter and page wrap.
  - enable=done; when enable=0 it holds counter 0 and page 0.

Test Plan (RST_CYCLES=4, STALL_LIMIT=3, TIMEOUT=20, DWELL=5):
- Reset high 2 cycles, then low → core_rst high for exactly 4 cycles after Reset falls; done=0; NumberA/B=0.
- PC runs 0,4,8,0x20,0x20,0x20 with v0=0x0005, v1=0x0003, sad=0x0001_0002 → done rises the cycle after the third 0x20; timeout=0; page0 shows NumberA=0x0003, NumberB=0x0005.
- PC pattern 4,4,8,8,C,C repeating (never 3 equal) → timeout=1, done=1, run_cycles=20.
- After done in the halt case, hold 16 cycles → page 0→1→2→0 every 5 cycles; page1 shows A=0x0001, B=0x0002; page2 shows run_cycles.
- Stall completes on exactly cycle TIMEOUT-1 → done=1, timeout=0.
- Reset pulsed mid-RUN and mid-DONE → next cycle: core_rst=1, done=0, run_cycles=0, NumberA/B=0; HOLD sequence restarts.
